// File: rtl/status_reg_bank.sv
// status_reg_bank: parametrised processor status register.
//
// Holds NUM_FLAGS flag bits. Updates can be masked per bit, and bits can be
// made sticky (OR-accumulate until cleared). A STACK_DEPTH-entry stack saves
// and restores the flags around interrupt/call entry and return.
//
// Optional feature macro: STATUS_IRQ_EN. When it is defined, irq_o pulses for
// one cycle on any 0->1 flag transition selected by IRQ_MASK. When it is
// undefined, irq_o is tied low.
//
// Ports:
//   clk_i           clock, rising edge
//   reset_ni        asynchronous reset, active-low
//   flags_in_i      new flag values from the ALU
//   update_en_i     apply flags_in_i this cycle
//   update_mask_i   per-bit enable for the update
//   clear_sticky_i  clear sticky flag i (ignored for non-sticky bits)
//   push_i          save the current flags_out_o onto the stack
//   pop_i           restore flags_out_o from the stack top
//   err_clr_i       clear stack_err_o
//   flags_out_o     registered flag state
//   stack_count_o   number of entries held
//   stack_full_o    stack_count_o == STACK_DEPTH
//   stack_empty_o   stack_count_o == 0
//   stack_err_o     sticky: push on full or pop on empty has been seen
//   irq_o           one-cycle flag-rise pulse
module status_reg_bank #(
  parameter int unsigned          NUM_FLAGS   = 4,
  parameter int unsigned          STACK_DEPTH = 4,
  parameter logic [NUM_FLAGS-1:0] STICKY_MASK = '0,
  parameter logic [NUM_FLAGS-1:0] IRQ_MASK    = '1
) (
  input  logic                             clk_i,
  input  logic                             reset_ni,
  input  logic [NUM_FLAGS-1:0]             flags_in_i,
  input  logic                             update_en_i,
  input  logic [NUM_FLAGS-1:0]             update_mask_i,
  input  logic [NUM_FLAGS-1:0]             clear_sticky_i,
  input  logic                             push_i,
  input  logic                             pop_i,
  input  logic                             err_clr_i,
  output logic [NUM_FLAGS-1:0]             flags_out_o,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_count_o,
  output logic                             stack_full_o,
  output logic                             stack_empty_o,
  output logic                             stack_err_o,
  output logic                             irq_o
);

  localparam int unsigned    CntW     = $clog2(STACK_DEPTH + 1);
  localparam int unsigned    IdxW     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(STACK_DEPTH);
  localparam logic [CntW-1:0] OneCnt   = CntW'(1);

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [NUM_FLAGS-1:0] flags_upd, upd_bits, clr_bits;
  logic [NUM_FLAGS-1:0] stack_q [STACK_DEPTH];
  logic [CntW-1:0]      count_q, count_d;
  logic                 err_q, err_d, err_hit;
  logic                 full, empty;
  logic                 stk_we;
  logic [IdxW-1:0]      stk_widx, top_idx;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthCnt);
  assign top_idx = IdxW'(count_q - OneCnt);

  // Flag update and sticky clear; a same-cycle set of a sticky bit beats its clear.
  always_comb begin
    upd_bits  = update_mask_i & {NUM_FLAGS{update_en_i}};
    clr_bits  = clear_sticky_i & STICKY_MASK & ~(upd_bits & flags_in_i);
    flags_upd = (flags_q & ~upd_bits) | (upd_bits & (flags_in_i | (flags_q & STICKY_MASK)));
    flags_upd = flags_upd & ~clr_bits;
  end

  // Stack control. A successful pop or swap overrides the update path.
  always_comb begin
    flags_d  = flags_upd;
    count_d  = count_q;
    stk_we   = 1'b0;
    stk_widx = top_idx;
    err_hit  = 1'b0;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (full) begin
          err_hit = 1'b1;
        end else begin
          stk_we   = 1'b1;
          stk_widx = IdxW'(count_q);
          count_d  = count_q + OneCnt;
        end
      end
      2'b01: begin
        if (empty) begin
          err_hit = 1'b1;
        end else begin
          flags_d = stack_q[top_idx];
          count_d = count_q - OneCnt;
        end
      end
      2'b11: begin
        if (empty) begin
          err_hit = 1'b1;
        end else begin
          flags_d = stack_q[top_idx];
          stk_we  = 1'b1;
        end
      end
      default: ;
    endcase
    err_d = err_hit | (err_q & ~err_clr_i);
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      flags_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      flags_q <= flags_d;
      count_q <= count_d;
      err_q   <= err_d;
      // Stack entries always capture the pre-update flags.
      if (stk_we) begin
        stack_q[stk_widx] <= flags_q;
      end
    end
  end

`ifdef STATUS_IRQ_EN
  logic irq_q;

  // Restores from pop/swap count as transitions too, since flags_d covers them.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |(flags_d & ~flags_q & IRQ_MASK);
    end
  end

  assign irq_o = irq_q;
`else
  logic unused_irq_mask;
  assign unused_irq_mask = ^IRQ_MASK;
  assign irq_o           = 1'b0;
`endif

  assign flags_out_o   = flags_q;
  assign stack_count_o = count_q;
  assign stack_full_o  = full;
  assign stack_empty_o = empty;
  assign stack_err_o   = err_q;

endmodule

// File: tb/tb_status_reg_bank.sv
// Directed bench for status_reg_bank (NUM_FLAGS=4, STACK_DEPTH=2, sticky bit 2,
// IRQ_MASK=4'b0010). Each step drives inputs, a behavioural model pushes the
// expected outputs to a scoreboard queue, and they are popped and compared one
// cycle later.
module tb_status_reg_bank;

  localparam int unsigned NF     = 4;
  localparam int unsigned SD     = 2;
  localparam logic [3:0]  STICKY = 4'b0100;
  localparam logic [3:0]  IRQM   = 4'b0010;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [3:0] flags_in, update_mask, clear_sticky;
  logic       update_en, push, pop, err_clr;
  logic [3:0] flags_out;
  logic [1:0] stack_count;
  logic       stack_full, stack_empty, stack_err, irq;

  status_reg_bank #(
    .NUM_FLAGS  (NF),
    .STACK_DEPTH(SD),
    .STICKY_MASK(STICKY),
    .IRQ_MASK   (IRQM)
  ) dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .flags_in_i    (flags_in),
    .update_en_i   (update_en),
    .update_mask_i (update_mask),
    .clear_sticky_i(clear_sticky),
    .push_i        (push),
    .pop_i         (pop),
    .err_clr_i     (err_clr),
    .flags_out_o   (flags_out),
    .stack_count_o (stack_count),
    .stack_full_o  (stack_full),
    .stack_empty_o (stack_empty),
    .stack_err_o   (stack_err),
    .irq_o         (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [3:0] flags;
    logic [1:0] count;
    logic       full;
    logic       empty;
    logic       err;
    logic       irq;
  } exp_t;

  exp_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [3:0] m_flags;
  logic [3:0] m_stack [SD];
  int         m_count;
  logic       m_err;
  logic       m_irq;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_flags = '0;
    m_count = 0;
    m_err   = 1'b0;
    m_irq   = 1'b0;
    for (int i = 0; i < SD; i++) m_stack[i] = '0;
  endtask

  task automatic model_step(input logic [3:0] fin, input logic ue, input logic [3:0] um,
                            input logic [3:0] cs, input logic ps, input logic pp,
                            input logic ec);
    logic [3:0] nf;
    logic [3:0] tmp;
    logic       hit;
    nf  = m_flags;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ue && um[i]) nf[i] = STICKY[i] ? (m_flags[i] | fin[i]) : fin[i];
      if (STICKY[i] && cs[i] && !(ue && um[i] && fin[i])) nf[i] = 1'b0;
    end
    if (ps && !pp) begin
      if (m_count == SD) hit = 1'b1;
      else begin
        m_stack[m_count] = m_flags;
        m_count++;
      end
    end else if (pp && !ps) begin
      if (m_count == 0) hit = 1'b1;
      else begin
        nf = m_stack[m_count-1];
        m_count--;
      end
    end else if (pp && ps) begin
      if (m_count == 0) hit = 1'b1;
      else begin
        tmp                = m_stack[m_count-1];
        m_stack[m_count-1] = m_flags;
        nf                 = tmp;
      end
    end
`ifdef STATUS_IRQ_EN
    m_irq = |(nf & ~m_flags & IRQM);
`else
    m_irq = 1'b0;
`endif
    m_err   = hit | (m_err & ~ec);
    m_flags = nf;
  endtask

  task automatic sb_check();
    exp_t e;
    e = sb_q.pop_front();
    check({e.tag, ".flags"}, 32'(flags_out), 32'(e.flags));
    check({e.tag, ".count"}, 32'(stack_count), 32'(e.count));
    check({e.tag, ".full"}, 32'(stack_full), 32'(e.full));
    check({e.tag, ".empty"}, 32'(stack_empty), 32'(e.empty));
    check({e.tag, ".err"}, 32'(stack_err), 32'(e.err));
    check({e.tag, ".irq"}, 32'(irq), 32'(e.irq));
  endtask

  // One clocked step; entered and left at posedge+1.
  task automatic drive(input string tag, input logic [3:0] fin, input logic ue,
                       input logic [3:0] um, input logic [3:0] cs, input logic ps,
                       input logic pp, input logic ec);
    exp_t e;
    flags_in     = fin;
    update_en    = ue;
    update_mask  = um;
    clear_sticky = cs;
    push         = ps;
    pop          = pp;
    err_clr      = ec;
    model_step(fin, ue, um, cs, ps, pp, ec);
    e.tag   = tag;
    e.flags = m_flags;
    e.count = 2'(m_count);
    e.full  = (m_count == SD);
    e.empty = (m_count == 0);
    e.err   = m_err;
    e.irq   = m_irq;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    flags_in     = '0;
    update_en    = 1'b0;
    update_mask  = '0;
    clear_sticky = '0;
    push         = 1'b0;
    pop          = 1'b0;
    err_clr      = 1'b0;
    sb_check();
  endtask

  task automatic upd(input string tag, input logic [3:0] fin);
    drive(tag, fin, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n      = 1'b0;
    flags_in     = '0;
    update_en    = 1'b0;
    update_mask  = '0;
    clear_sticky = '0;
    push         = 1'b0;
    pop          = 1'b0;
    err_clr      = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check("rst.flags", 32'(flags_out), 32'h0);
    check("rst.count", 32'(stack_count), 32'h0);
    check("rst.empty", 32'(stack_empty), 32'h1);
    check("rst.full", 32'(stack_full), 32'h0);
    check("rst.err", 32'(stack_err), 32'h0);
    check("rst.irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Masked update
    drive("upd_mask", 4'b1111, 1'b1, 4'b0011, 4'b0000, 1'b0, 1'b0, 1'b0);
    check("upd_mask.spec", 32'(flags_out), 32'h3);
    upd("upd_all0", 4'b0000);
    drive("upd_off", 4'b1111, 1'b0, 4'b1111, 4'b0000, 1'b0, 1'b0, 1'b0);

    // Sticky bit 2
    upd("stk_set", 4'b0100);
    upd("stk_hold", 4'b0000);
    check("stk_hold.spec", 32'(flags_out[2]), 32'h1);
    drive("stk_setwins", 4'b0100, 1'b1, 4'b1111, 4'b0100, 1'b0, 1'b0, 1'b0);
    drive("stk_clr", 4'b0000, 1'b0, 4'b0000, 4'b0100, 1'b0, 1'b0, 1'b0);
    check("stk_clr.spec", 32'(flags_out), 32'h0);
    drive("stk_clr_nonsticky", 4'b1011, 1'b1, 4'b1111, 4'b1011, 1'b0, 1'b0, 1'b0);
    upd("clr0", 4'b0000);

    // Flag-rise interrupt
    upd("irq_b1", 4'b0010);
    drive("irq_idle", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0);
    upd("irq_b0", 4'b0011);
    upd("irq_clr", 4'b0000);

    // Push/pop, full and empty errors
    upd("f1", 4'b0001);
    drive("push1", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    upd("f2", 4'b0010);
    drive("push2", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("push2.full", 32'(stack_full), 32'h1);
    drive("push_full", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    check("push_full.err", 32'(stack_err), 32'h1);
    drive("pop1", 4'b1111, 1'b1, 4'b1111, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("pop1.spec", 32'(flags_out), 32'h2);
    drive("pop2", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("pop2.spec", 32'(flags_out), 32'h1);
    drive("pop_empty", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    drive("swap_empty", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1);
    drive("errclr", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);

    // Swap, then err_clr
    upd("f8", 4'b1000);
    drive("push_upd", 4'b0001, 1'b1, 4'b1111, 4'b0000, 1'b1, 1'b0, 1'b0);
    drive("swap", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    check("swap.spec", 32'(flags_out), 32'h8);
    drive("pop_after_swap", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    check("pop_after_swap.spec", 32'(flags_out), 32'h1);
    drive("err_set", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);
    drive("err_clr", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1);
    check("err_clr.spec", 32'(stack_err), 32'h0);

    // Asynchronous reset mid-traffic
    upd("f11", 4'b1011);
    drive("push_pre_rst", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 1'b0);
    drive("pop_pre_rst", 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst.flags", 32'(flags_out), 32'h0);
    check("async_rst.count", 32'(stack_count), 32'h0);
    check("async_rst.empty", 32'(stack_empty), 32'h1);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    drive("post_rst_pop", 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0);

    check("sb_drain", 32'(sb_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
